mem_access_ctrl: RTL and testbench

- Memory-stage access controller, directly downstream of the EX/MEM pipeline register.
- Takes the registered ALU result (address), write data and MemRd/MemWrt/halt controls, and drives a multi-cycle data-memory handshake (Rd/Wr/Done).
- Produces mem_stall, which freezes EX/MEM and upstream stages, and a held read-data word for MEM/WB.
- Also tracks alignment/memory errors, a request timeout, and sticky halt.

---
 rtl/mem_access_ctrl.sv | 130 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: drives a level Rd/Wr handshake to data memory from EX/MEM, N-cycle access = N stall cycles.
// Backpressure: mem_stall holds EX/MEM while a request is outstanding; DONE waits out fetch_stall without reissuing.
module mem_access_ctrl #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic              MemRd_in,
  input  logic              MemWrt_in,
  input  logic              SendNOP_in,
  input  logic              halt_in,
  input  logic              fetch_stall,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_err,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              mem_stall,
  output logic [DATA_W-1:0] rd_data,
  output logic              err,
  output logic              halted
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              req_rd, req_rd_nxt;
  logic              req_wr, req_wr_nxt;
  logic [DATA_W-1:0] rd_data_nxt;
  logic              err_nxt, halted_nxt;
  logic              rd_c, wr_c, stall_c;
  logic              access, misalign;

  assign access   = (MemRd_in | MemWrt_in) & ~SendNOP_in & ~halted & ~err;
  assign misalign = access & addr_in[0];

  assign mem_addr  = addr_in;
  assign mem_wdata = wdata_in;

  // Gate with reset so the request drops the instant reset asserts, even if EX/MEM still shows an access.
  assign mem_rd    = rd_c & rst;
  assign mem_wr    = wr_c & rst;
  assign mem_stall = stall_c & rst;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    req_rd_nxt  = req_rd;
    req_wr_nxt  = req_wr;
    rd_data_nxt = rd_data;
    err_nxt     = err;
    rd_c        = 1'b0;
    wr_c        = 1'b0;
    stall_c     = 1'b0;
    case (state)
      IDLE: begin
        if (misalign) begin
          err_nxt = 1'b1;
        end else if (access) begin
          rd_c       = MemRd_in;
          wr_c       = MemWrt_in & ~MemRd_in;
          stall_c    = 1'b1;
          req_rd_nxt = rd_c;
          req_wr_nxt = wr_c;
          if (mem_done) begin
            if (rd_c) rd_data_nxt = mem_rdata;
            err_nxt   = err | mem_err;
            state_nxt = DONE;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = CNT_W'(1);
          end
        end
      end
      BUSY: begin
        rd_c    = req_rd;
        wr_c    = req_wr;
        stall_c = 1'b1;
        if (mem_done) begin
          if (req_rd) rd_data_nxt = mem_rdata;
          err_nxt   = err | mem_err;
          state_nxt = DONE;
        end else if (cnt == CNT_W'(TIMEOUT)) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        // EX/MEM still holds the finished access while fetch_stall is high; never reissue it.
        if (!fetch_stall) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
    halted_nxt = halted | (halt_in & ~SendNOP_in & ~stall_c);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      req_rd  <= 1'b0;
      req_wr  <= 1'b0;
      rd_data <= '0;
      err     <= 1'b0;
      halted  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      req_rd  <= req_rd_nxt;
      req_wr  <= req_wr_nxt;
      rd_data <= rd_data_nxt;
      err     <= err_nxt;
      halted  <= halted_nxt;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl (TIMEOUT=8): hits, misses, DONE hold, halt, errors, timeout, async reset.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr_in, wdata_in, mem_rdata;
  logic        MemRd_in, MemWrt_in, SendNOP_in, halt_in, fetch_stall, mem_done, mem_err;
  logic [15:0] mem_addr, mem_wdata, rd_data;
  logic        mem_rd, mem_wr, mem_stall, err, halted;

  int checks = 0;
  int errors = 0;

  mem_access_ctrl #(.DATA_W(16), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .addr_in(addr_in), .wdata_in(wdata_in),
    .MemRd_in(MemRd_in), .MemWrt_in(MemWrt_in), .SendNOP_in(SendNOP_in),
    .halt_in(halt_in), .fetch_stall(fetch_stall), .mem_done(mem_done),
    .mem_rdata(mem_rdata), .mem_err(mem_err), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_stall(mem_stall), .rd_data(rd_data), .err(err), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    addr_in = '0; wdata_in = '0; mem_rdata = '0;
    MemRd_in = 0; MemWrt_in = 0; SendNOP_in = 0; halt_in = 0;
    fetch_stall = 0; mem_done = 0; mem_err = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    cyc();
    #3;
    checks++; if (mem_rd !== 1'b0)     begin errors++; $display("FAIL reset_rd: got %b exp 0", mem_rd); end
    checks++; if (mem_wr !== 1'b0)     begin errors++; $display("FAIL reset_wr: got %b exp 0", mem_wr); end
    checks++; if (mem_stall !== 1'b0)  begin errors++; $display("FAIL reset_stall: got %b exp 0", mem_stall); end
    checks++; if (rd_data !== 16'h0)   begin errors++; $display("FAIL reset_rd_data: got %h exp 0000", rd_data); end
    checks++; if (err !== 1'b0)        begin errors++; $display("FAIL reset_err: got %b exp 0", err); end
    checks++; if (halted !== 1'b0)     begin errors++; $display("FAIL reset_halted: got %b exp 0", halted); end
    cyc();
    rst = 1'b1;
  endtask

  task automatic test_load_hit();
    cyc();
    addr_in = 16'h0010; MemRd_in = 1; mem_done = 1; mem_rdata = 16'hBEEF;
    #3;
    checks++; if (mem_rd !== 1'b1)       begin errors++; $display("FAIL hit_rd: got %b exp 1", mem_rd); end
    checks++; if (mem_stall !== 1'b1)    begin errors++; $display("FAIL hit_stall: got %b exp 1", mem_stall); end
    checks++; if (mem_addr !== 16'h0010) begin errors++; $display("FAIL hit_addr: got %h exp 0010", mem_addr); end
    cyc();
    mem_done = 0; mem_rdata = 16'h0;
    #3;
    checks++; if (mem_stall !== 1'b0)    begin errors++; $display("FAIL hit_stall_done: got %b exp 0", mem_stall); end
    checks++; if (mem_rd !== 1'b0)       begin errors++; $display("FAIL hit_rd_done: got %b exp 0", mem_rd); end
    checks++; if (rd_data !== 16'hBEEF)  begin errors++; $display("FAIL hit_rd_data: got %h exp BEEF", rd_data); end
    cyc();
    MemRd_in = 0;
    // Load and store both set: the load wins.
    cyc();
    addr_in = 16'h0014; MemRd_in = 1; MemWrt_in = 1; mem_done = 1; mem_rdata = 16'h0F0F;
    #3;
    checks++; if (mem_rd !== 1'b1)       begin errors++; $display("FAIL both_rd: got %b exp 1", mem_rd); end
    checks++; if (mem_wr !== 1'b0)       begin errors++; $display("FAIL both_wr: got %b exp 0", mem_wr); end
    cyc();
    mem_done = 0;
    #3;
    checks++; if (rd_data !== 16'h0F0F)  begin errors++; $display("FAIL both_rd_data: got %h exp 0F0F", rd_data); end
    cyc();
    MemRd_in = 0; MemWrt_in = 0;
  endtask

  task automatic test_store_miss();
    cyc();
    addr_in = 16'h0020; wdata_in = 16'h1234; MemWrt_in = 1;
    for (int i = 0; i < 4; i++) begin
      mem_done = (i == 3);
      #3;
      checks++; if (mem_wr !== 1'b1)        begin errors++; $display("FAIL st_wr[%0d]: got %b exp 1", i, mem_wr); end
      checks++; if (mem_stall !== 1'b1)     begin errors++; $display("FAIL st_stall[%0d]: got %b exp 1", i, mem_stall); end
      checks++; if (mem_wdata !== 16'h1234) begin errors++; $display("FAIL st_wdata[%0d]: got %h exp 1234", i, mem_wdata); end
      cyc();
    end
    mem_done = 0;
    #3;
    checks++; if (mem_stall !== 1'b0)    begin errors++; $display("FAIL st_stall_done: got %b exp 0", mem_stall); end
    checks++; if (mem_wr !== 1'b0)       begin errors++; $display("FAIL st_wr_done: got %b exp 0", mem_wr); end
    checks++; if (rd_data !== 16'h0F0F)  begin errors++; $display("FAIL st_rd_data: got %h exp 0F0F", rd_data); end
    cyc();
    MemWrt_in = 0;
  endtask

  task automatic test_done_fetch_stall();
    cyc();
    addr_in = 16'h0030; MemRd_in = 1;
    #3;
    checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL fs_req: got %b exp 1", mem_rd); end
    cyc();
    mem_done = 1; mem_rdata = 16'hCAFE;
    #3;
    checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL fs_busy_stall: got %b exp 1", mem_stall); end
    cyc();
    mem_done = 0; mem_rdata = 16'h0; fetch_stall = 1;
    for (int i = 0; i < 3; i++) begin
      #3;
      checks++; if (mem_rd !== 1'b0)      begin errors++; $display("FAIL fs_rd[%0d]: got %b exp 0", i, mem_rd); end
      checks++; if (mem_stall !== 1'b0)   begin errors++; $display("FAIL fs_stall[%0d]: got %b exp 0", i, mem_stall); end
      checks++; if (rd_data !== 16'hCAFE) begin errors++; $display("FAIL fs_rd_data[%0d]: got %h exp CAFE", i, rd_data); end
      cyc();
    end
    fetch_stall = 0;
    #3;
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL fs_release_rd: got %b exp 0", mem_rd); end
    cyc();
    addr_in = 16'h0040; mem_done = 1; mem_rdata = 16'h5A5A;
    #3;
    checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL fs_next_rd: got %b exp 1", mem_rd); end
    cyc();
    mem_done = 0;
    #3;
    checks++; if (rd_data !== 16'h5A5A) begin errors++; $display("FAIL fs_next_data: got %h exp 5A5A", rd_data); end
    cyc();
    MemRd_in = 0;
  endtask

  task automatic test_reset_mid_busy();
    cyc();
    addr_in = 16'h0060; MemRd_in = 1;
    #3;
    checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL rmb_rd: got %b exp 1", mem_rd); end
    cyc();
    #2;
    rst = 1'b0;
    #1;
    checks++; if (mem_rd !== 1'b0)    begin errors++; $display("FAIL rmb_rd_drop: got %b exp 0", mem_rd); end
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL rmb_stall_drop: got %b exp 0", mem_stall); end
    cyc();
    MemRd_in = 0;
    rst = 1'b1;
    #3;
    checks++; if (rd_data !== 16'h0)  begin errors++; $display("FAIL rmb_rd_data: got %h exp 0000", rd_data); end
    checks++; if (err !== 1'b0)       begin errors++; $display("FAIL rmb_err: got %b exp 0", err); end
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL rmb_stall: got %b exp 0", mem_stall); end
  endtask

  task automatic test_halt();
    cyc();
    addr_in = 16'h0050; MemRd_in = 1; SendNOP_in = 1; halt_in = 1;
    #3;
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL nop_rd: got %b exp 0", mem_rd); end
    cyc();
    MemRd_in = 0;
    #3;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL nop_halt: got %b exp 0", halted); end
    SendNOP_in = 0;
    cyc();
    halt_in = 0;
    #3;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_set: got %b exp 1", halted); end
    MemRd_in = 1; mem_done = 1; mem_rdata = 16'h7777;
    #1;
    checks++; if (mem_rd !== 1'b0)    begin errors++; $display("FAIL halt_rd: got %b exp 0", mem_rd); end
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL halt_stall: got %b exp 0", mem_stall); end
    cyc();
    MemRd_in = 0; mem_done = 0;
    #3;
    checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL halt_rd_data: got %h exp 0000", rd_data); end
  endtask

  task automatic test_misalign();
    cyc();
    addr_in = 16'h0011; MemRd_in = 1;
    #3;
    checks++; if (mem_rd !== 1'b0)    begin errors++; $display("FAIL mis_rd: got %b exp 0", mem_rd); end
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL mis_stall: got %b exp 0", mem_stall); end
    checks++; if (err !== 1'b0)       begin errors++; $display("FAIL mis_err_early: got %b exp 0", err); end
    cyc();
    #3;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL mis_err: got %b exp 1", err); end
    addr_in = 16'h0012;
    #1;
    checks++; if (mem_rd !== 1'b0)    begin errors++; $display("FAIL mis_block_rd: got %b exp 0", mem_rd); end
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL mis_block_stall: got %b exp 0", mem_stall); end
    cyc();
    MemRd_in = 0;
  endtask

  task automatic test_store_err();
    cyc();
    addr_in = 16'h0022; wdata_in = 16'hAAAA; MemWrt_in = 1; mem_done = 1; mem_err = 1;
    #3;
    checks++; if (mem_wr !== 1'b1)    begin errors++; $display("FAIL se_wr: got %b exp 1", mem_wr); end
    checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL se_stall: got %b exp 1", mem_stall); end
    cyc();
    mem_done = 0; mem_err = 0;
    #3;
    checks++; if (err !== 1'b1)       begin errors++; $display("FAIL se_err: got %b exp 1", err); end
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL se_stall_done: got %b exp 0", mem_stall); end
    checks++; if (rd_data !== 16'h0)  begin errors++; $display("FAIL se_rd_data: got %h exp 0000", rd_data); end
    cyc();
    MemWrt_in = 0;
  endtask

  task automatic test_timeout();
    cyc();
    addr_in = 16'h0070; MemRd_in = 1;
    // One request cycle in IDLE plus eight BUSY cycles before the abort.
    for (int i = 0; i < 9; i++) begin
      #3;
      checks++; if (mem_rd !== 1'b1)    begin errors++; $display("FAIL to_rd[%0d]: got %b exp 1", i, mem_rd); end
      checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL to_stall[%0d]: got %b exp 1", i, mem_stall); end
      checks++; if (err !== 1'b0)       begin errors++; $display("FAIL to_err_early[%0d]: got %b exp 0", i, err); end
      cyc();
    end
    #3;
    checks++; if (err !== 1'b1)       begin errors++; $display("FAIL to_err: got %b exp 1", err); end
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL to_stall_release: got %b exp 0", mem_stall); end
    checks++; if (mem_rd !== 1'b0)    begin errors++; $display("FAIL to_rd_release: got %b exp 0", mem_rd); end
    cyc();
    MemRd_in = 0;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_load_hit();
    test_store_miss();
    test_done_fetch_stall();
    test_reset_mid_busy();
    test_halt();
    test_reset();
    test_misalign();
    test_reset();
    test_store_err();
    test_reset();
    test_timeout();
    test_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
